// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator for the decode stage.
// A word plus format select is accepted over valid/ready. The extended
// immediate, tag and illegal-format flag come back one cycle later from a
// registered main stage. A single skid entry behind it lets in_ready be a
// pure register, so there is no combinational out_ready -> in_ready path.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef struct packed {
    logic [31:0] imm;
    logic        err;
  } imm_res_t;

  // All formats are built as a 32-bit signed value. Z keeps bit 31 clear, so
  // sign extension to XLEN leaves it zero-extended.
  function automatic imm_res_t f_gen_imm(input logic [31:0] instr,
                                         input logic [2:0]  src);
    imm_res_t r;
    r.imm = 32'd0;
    r.err = 1'b0;
    case (src)
      3'b000: r.imm = {{20{instr[31]}}, instr[31:20]};
      3'b001: r.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: r.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
      3'b011: r.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
      3'b100: r.imm = {instr[31:12], 12'd0};
      3'b101: r.imm = {27'd0, instr[19:15]};
      default: begin
        r.imm = 32'd0;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

  // Opcode field does not influence the immediate.
  logic w_unused_opcode;
  assign w_unused_opcode = ^in_instr[6:0];

  imm_res_t        w_res;
  logic [XLEN-1:0] w_imm;

  assign w_res = f_gen_imm(in_instr, in_immsrc);

  if (XLEN > 32) begin : g_ext
    assign w_imm = {{(XLEN-32){w_res.imm[31]}}, w_res.imm};
  end else begin : g_noext
    assign w_imm = w_res.imm[XLEN-1:0];
  end

  logic             r_main_valid;
  logic [XLEN-1:0]  r_main_imm;
  logic [TAG_W-1:0] r_main_tag;
  logic             r_main_err;
  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [TAG_W-1:0] r_skid_tag;
  logic             r_skid_err;

  logic w_acc;
  logic w_drn;
  logic w_main_from_skid;
  logic w_main_from_in;
  logic w_skid_load;
  logic w_main_valid_nxt;
  logic w_skid_valid_nxt;

  assign w_acc = in_valid & ~r_skid_valid;
  assign w_drn = r_main_valid & out_ready;

  // Decide where the main and skid registers take their next contents from.
  always_comb begin
    w_main_from_skid = 1'b0;
    w_main_from_in   = 1'b0;
    w_skid_load      = 1'b0;
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    if (!r_main_valid || w_drn) begin
      if (r_skid_valid) begin
        w_main_from_skid = 1'b1;
        w_main_valid_nxt = 1'b1;
        w_skid_load      = w_acc;
        w_skid_valid_nxt = w_acc;
      end else if (w_acc) begin
        w_main_from_in   = 1'b1;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else begin
        w_main_valid_nxt = 1'b0;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_skid_load      = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end else begin
      w_skid_load      = 1'b0;
    end
  end

  // Main output stage: holds the word presented to downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_main_imm   <= '0;
      r_main_tag   <= '0;
      r_main_err   <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      if (w_main_from_skid) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
        r_main_err <= r_skid_err;
      end else if (w_main_from_in) begin
        r_main_imm <= w_imm;
        r_main_tag <= in_tag;
        r_main_err <= w_res.err;
      end
    end
  end

  // Skid entry: absorbs one word accepted while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tag   <= '0;
      r_skid_err   <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_valid_nxt;
      if (w_skid_load) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= in_tag;
        r_skid_err <= w_res.err;
      end
    end
  end

  assign in_ready  = ~r_skid_valid;
  assign out_valid = r_main_valid;
  assign out_imm   = r_main_imm;
  assign out_tag   = r_main_tag;
  assign out_err   = r_main_err;

endmodule
